// File: rtl/arrow_queue_pkg.sv
// Shared codes for the arrow game: game state encoding and arrow symbols.
// Imported by the arrow queue and the blocks that share its beat and state buses.
package arrow_queue_pkg;

    localparam int STATE_BITS = 2;

    typedef enum logic [STATE_BITS-1:0] {
        STATE_GAME  = 2'd0,
        STATE_PAUSE = 2'd1,
        STATE_RESET = 2'd2
    } game_state_e;

    localparam int ARROW_UP         = 0;
    localparam int ARROW_DOWN       = 1;
    localparam int ARROW_LEFT       = 2;
    localparam int ARROW_RIGHT      = 3;
    localparam int ARROW_UP_DOWN    = 4;
    localparam int ARROW_UP_LEFT    = 5;
    localparam int ARROW_UP_RIGHT   = 6;
    localparam int ARROW_DOWN_LEFT  = 7;
    localparam int ARROW_DOWN_RIGHT = 8;
    localparam int ARROW_LEFT_RIGHT = 9;
    localparam int ARROW_NONE       = 20;

endpackage

// File: rtl/arrow_queue_beat_sync.sv
// Two-flop synchroniser for an asynchronous beat clock followed by a rising-edge
// detector; pulse is high for one clk cycle per rising edge of async_in.
module beat_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic pulse
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= async_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign pulse = s2 & ~s3;

endmodule

// File: rtl/arrow_queue.sv
// Arrow slot queue: shifts in a new arrow on each metronome beat during play,
// lets the player consume the oldest arrow, and flags arrows that fall off unplayed.
module arrow_queue
    import arrow_queue_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int ARROW_W    = 5,
    parameter int EMPTY_CODE = ARROW_NONE,
    parameter int STATE_W    = STATE_BITS
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [STATE_W-1:0]           state,
    input  logic                         metronome_clk,
    input  logic [ARROW_W-1:0]           next_arrow,
    input  logic                         hit,
    output logic [DEPTH*ARROW_W-1:0]     arrows,
    output logic                         step,
    output logic                         miss,
    output logic [ARROW_W-1:0]           miss_arrow,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [ARROW_W-1:0] EMPTY = ARROW_W'(EMPTY_CODE);

    logic                 beat;
    logic [ARROW_W-1:0]   slots_q [DEPTH];
    logic [ARROW_W-1:0]   slots_n [DEPTH];
    logic                 step_n;
    logic                 miss_n;
    logic [ARROW_W-1:0]   miss_arrow_n;
    logic [OCC_W-1:0]     occ_n;
    logic                 in_game;
    logic                 in_reset;

    // The synchroniser ignores the RESET game state so a held beat clock is not re-seen as an edge.
    beat_sync u_beat_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (metronome_clk),
        .pulse    (beat)
    );

    assign in_game  = (state == STATE_W'(STATE_GAME));
    assign in_reset = (state == STATE_W'(STATE_RESET));

    always_comb begin
        slots_n      = slots_q;
        step_n       = 1'b0;
        miss_n       = 1'b0;
        miss_arrow_n = miss_arrow;
        occ_n        = '0;

        if (in_reset) begin
            for (int i = 0; i < DEPTH; i++) slots_n[i] = EMPTY;
            miss_arrow_n = EMPTY;
        end else if (in_game) begin
            if (beat) begin
                slots_n[0] = next_arrow;
                for (int i = 1; i < DEPTH; i++) slots_n[i] = slots_q[i-1];
                step_n = 1'b1;
                // A hit on the beat cycle consumes the outgoing arrow, so it is not a miss.
                if (slots_q[DEPTH-1] != EMPTY && !hit) begin
                    miss_n       = 1'b1;
                    miss_arrow_n = slots_q[DEPTH-1];
                end
            end else if (hit) begin
                slots_n[DEPTH-1] = EMPTY;
            end
        end

        for (int i = 0; i < DEPTH; i++) begin
            if (slots_n[i] != EMPTY) occ_n = occ_n + OCC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) slots_q[i] <= EMPTY;
            step       <= 1'b0;
            miss       <= 1'b0;
            miss_arrow <= EMPTY;
            occupancy  <= '0;
        end else begin
            slots_q    <= slots_n;
            step       <= step_n;
            miss       <= miss_n;
            miss_arrow <= miss_arrow_n;
            occupancy  <= occ_n;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_arrows
        assign arrows[g*ARROW_W +: ARROW_W] = slots_q[g];
    end

endmodule

// File: tb/tb_arrow_queue.sv
// Directed bench for arrow_queue at DEPTH=4, ARROW_W=5, empty code 20.
module tb_arrow_queue;

    logic        clk;
    logic        rst_n;
    logic [1:0]  state;
    logic        metronome_clk;
    logic [4:0]  next_arrow;
    logic        hit;
    logic [19:0] arrows;
    logic        step;
    logic        miss;
    logic [4:0]  miss_arrow;
    logic [2:0]  occupancy;

    int checks;
    int errors;

    arrow_queue #(
        .DEPTH      (4),
        .ARROW_W    (5),
        .EMPTY_CODE (20),
        .STATE_W    (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .state         (state),
        .metronome_clk (metronome_clk),
        .next_arrow    (next_arrow),
        .hit           (hit),
        .arrows        (arrows),
        .step          (step),
        .miss          (miss),
        .miss_arrow    (miss_arrow),
        .occupancy     (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All driving and sampling happens 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise the beat clock; returns just after the edge that applies the shift.
    task automatic beat_head(input logic [4:0] code, input logic hit_on_beat);
        next_arrow    = code;
        metronome_clk = 1'b1;
        tick();
        tick();
        hit = hit_on_beat;
        tick();
        hit = 1'b0;
    endtask

    // Lower the beat clock and let the edge detector settle low again.
    task automatic beat_tail();
        metronome_clk = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        state = 2'd0;
        metronome_clk = 1'b0;
        next_arrow = 5'd0;
        hit = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        checks++; if (arrows !== {5'd20, 5'd20, 5'd20, 5'd20}) begin errors++; $display("FAIL reset_arrows got %h want %h", arrows, {5'd20, 5'd20, 5'd20, 5'd20}); end
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occ got %0d want 0", occupancy); end
        checks++; if (step !== 1'b0) begin errors++; $display("FAIL reset_step got %b want 0", step); end
        checks++; if (miss !== 1'b0) begin errors++; $display("FAIL reset_miss got %b want 0", miss); end
        checks++; if (miss_arrow !== 5'd20) begin errors++; $display("FAIL reset_miss_arrow got %0d want 20", miss_arrow); end
    endtask

    task automatic test_single_beat();
        next_arrow = 5'd10;
        metronome_clk = 1'b1;
        tick();
        checks++; if (step !== 1'b0) begin errors++; $display("FAIL latency_edge1_step got %b want 0", step); end
        tick();
        checks++; if (step !== 1'b0 || arrows !== {5'd20, 5'd20, 5'd20, 5'd20}) begin errors++; $display("FAIL latency_edge2 step %b arrows %h want 0 and all empty", step, arrows); end
        tick();
        checks++; if (step !== 1'b1) begin errors++; $display("FAIL single_step got %b want 1", step); end
        checks++; if (arrows !== {5'd20, 5'd20, 5'd20, 5'd10}) begin errors++; $display("FAIL single_arrows got %h want %h", arrows, {5'd20, 5'd20, 5'd20, 5'd10}); end
        checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL single_occ got %0d want 1", occupancy); end
        checks++; if (miss !== 1'b0) begin errors++; $display("FAIL single_miss got %b want 0", miss); end
        // Holding the beat clock high must not produce another shift.
        tick();
        checks++; if (step !== 1'b0) begin errors++; $display("FAIL single_step_width got %b want 0", step); end
        tick();
        tick();
        checks++; if (step !== 1'b0 || arrows !== {5'd20, 5'd20, 5'd20, 5'd10}) begin errors++; $display("FAIL held_high step %b arrows %h", step, arrows); end
        beat_tail();
    endtask

    task automatic test_fill_miss();
        logic [4:0] codes [4];
        codes[0] = 5'd10; codes[1] = 5'd11; codes[2] = 5'd12; codes[3] = 5'd13;
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            beat_head(codes[k], 1'b0);
            checks++; if (occupancy !== 3'(k + 1) || miss !== 1'b0) begin errors++; $display("FAIL fill_%0d occ %0d miss %b want occ %0d miss 0", k, occupancy, miss, k + 1); end
            beat_tail();
        end
        checks++; if (arrows !== {5'd10, 5'd11, 5'd12, 5'd13}) begin errors++; $display("FAIL fill_arrows got %h want %h", arrows, {5'd10, 5'd11, 5'd12, 5'd13}); end
        beat_head(5'd14, 1'b0);
        checks++; if (arrows !== {5'd11, 5'd12, 5'd13, 5'd14}) begin errors++; $display("FAIL overflow_arrows got %h want %h", arrows, {5'd11, 5'd12, 5'd13, 5'd14}); end
        checks++; if (miss !== 1'b1 || miss_arrow !== 5'd10) begin errors++; $display("FAIL overflow_miss miss %b code %0d want 1 and 10", miss, miss_arrow); end
        checks++; if (occupancy !== 3'd4 || step !== 1'b1) begin errors++; $display("FAIL overflow_occ occ %0d step %b want 4 and 1", occupancy, step); end
        tick();
        checks++; if (miss !== 1'b0 || step !== 1'b0) begin errors++; $display("FAIL miss_width miss %b step %b want 0 0", miss, step); end
        metronome_clk = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_hit_between();
        hit = 1'b1;
        tick();
        hit = 1'b0;
        checks++; if (arrows !== {5'd20, 5'd12, 5'd13, 5'd14}) begin errors++; $display("FAIL hit_arrows got %h want %h", arrows, {5'd20, 5'd12, 5'd13, 5'd14}); end
        checks++; if (occupancy !== 3'd3 || miss !== 1'b0 || step !== 1'b0) begin errors++; $display("FAIL hit_flags occ %0d miss %b step %b want 3 0 0", occupancy, miss, step); end
        hit = 1'b1;
        tick();
        hit = 1'b0;
        checks++; if (arrows !== {5'd20, 5'd12, 5'd13, 5'd14} || occupancy !== 3'd3) begin errors++; $display("FAIL hit_empty arrows %h occ %0d", arrows, occupancy); end
        beat_head(5'd15, 1'b0);
        checks++; if (miss !== 1'b0 || step !== 1'b1) begin errors++; $display("FAIL after_hit_beat miss %b step %b want 0 1", miss, step); end
        checks++; if (arrows !== {5'd12, 5'd13, 5'd14, 5'd15} || occupancy !== 3'd4) begin errors++; $display("FAIL after_hit_arrows %h occ %0d", arrows, occupancy); end
        beat_tail();
    endtask

    task automatic test_hit_with_beat();
        beat_head(5'd16, 1'b1);
        checks++; if (step !== 1'b1 || miss !== 1'b0) begin errors++; $display("FAIL hit_beat step %b miss %b want 1 0", step, miss); end
        checks++; if (arrows !== {5'd13, 5'd14, 5'd15, 5'd16} || occupancy !== 3'd4) begin errors++; $display("FAIL hit_beat_arrows %h occ %0d", arrows, occupancy); end
        beat_tail();
    endtask

    task automatic test_pause();
        int steps_seen;
        steps_seen = 0;
        state = 2'd1;
        hit = 1'b1;
        tick();
        hit = 1'b0;
        checks++; if (arrows !== {5'd13, 5'd14, 5'd15, 5'd16} || occupancy !== 3'd4) begin errors++; $display("FAIL pause_hit arrows %h occ %0d", arrows, occupancy); end
        next_arrow = 5'd17;
        metronome_clk = 1'b1;
        for (int k = 0; k < 4; k++) begin tick(); if (step) steps_seen++; end
        metronome_clk = 1'b0;
        for (int k = 0; k < 3; k++) begin tick(); if (step) steps_seen++; end
        state = 2'd3;
        hit = 1'b1;
        tick();
        hit = 1'b0;
        if (step) steps_seen++;
        state = 2'd0;
        for (int k = 0; k < 5; k++) begin tick(); if (step || miss) steps_seen++; end
        checks++; if (steps_seen !== 0) begin errors++; $display("FAIL pause_step count %0d want 0", steps_seen); end
        checks++; if (arrows !== {5'd13, 5'd14, 5'd15, 5'd16} || occupancy !== 3'd4) begin errors++; $display("FAIL pause_resume arrows %h occ %0d", arrows, occupancy); end
    endtask

    task automatic test_gap();
        beat_head(5'd20, 1'b0);
        checks++; if (arrows !== {5'd14, 5'd15, 5'd16, 5'd20} || occupancy !== 3'd3) begin errors++; $display("FAIL gap_arrows %h occ %0d want %h 3", arrows, occupancy, {5'd14, 5'd15, 5'd16, 5'd20}); end
        checks++; if (miss !== 1'b1 || miss_arrow !== 5'd13) begin errors++; $display("FAIL gap_miss miss %b code %0d want 1 13", miss, miss_arrow); end
        beat_tail();
    endtask

    task automatic test_reset_mid();
        int steps_seen;
        steps_seen = 0;
        apply_reset();
        checks++; if (arrows !== {5'd20, 5'd20, 5'd20, 5'd20} || occupancy !== 3'd0) begin errors++; $display("FAIL mid_rst arrows %h occ %0d", arrows, occupancy); end
        checks++; if (step !== 1'b0 || miss !== 1'b0) begin errors++; $display("FAIL mid_rst_flags step %b miss %b", step, miss); end
        beat_head(5'd10, 1'b0);
        beat_tail();
        checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL refill occ %0d want 1", occupancy); end
        state = 2'd2;
        metronome_clk = 1'b1;
        tick();
        checks++; if (arrows !== {5'd20, 5'd20, 5'd20, 5'd20} || occupancy !== 3'd0 || step !== 1'b0 || miss !== 1'b0) begin errors++; $display("FAIL state_rst arrows %h occ %0d step %b miss %b", arrows, occupancy, step, miss); end
        tick();
        tick();
        state = 2'd0;
        for (int k = 0; k < 5; k++) begin tick(); if (step) steps_seen++; end
        checks++; if (steps_seen !== 0 || arrows !== {5'd20, 5'd20, 5'd20, 5'd20}) begin errors++; $display("FAIL held_across_reset steps %0d arrows %h", steps_seen, arrows); end
        beat_tail();
        beat_head(5'd12, 1'b0);
        checks++; if (step !== 1'b1 || arrows !== {5'd20, 5'd20, 5'd20, 5'd12} || occupancy !== 3'd1) begin errors++; $display("FAIL post_reset_beat step %b arrows %h occ %0d", step, arrows, occupancy); end
        beat_tail();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_beat();
        test_fill_miss();
        test_hit_between();
        test_hit_with_beat();
        test_pause();
        test_gap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/arrow_queue.md
Name: arrow_queue

Overview:
- Parametrised successor to the 4-slot arrow shift buffer.
- Holds DEPTH arrow codes of ARROW_W bits and advances them one slot per metronome beat while in game state.
- Adds hit-consume of the last slot, miss detection when an unconsumed arrow falls off the end, and a live occupancy count.
- Sits between the random arrow generator and the display/collision logic.

Parameters:
DEPTH, 4, number of arrow slots (>= 2)
ARROW_W, 5, arrow code width
EMPTY_CODE, 20, code for an empty slot (fits in ARROW_W)
STATE_W, 2, width of the game state bus; codes GAME=0, PAUSE=1, RESET=2, 3 treated as PAUSE

Ports:
clk  in  1  system clock
rst_n  in  1  reset; synchronous, active-low
state  in  STATE_W  game state
metronome_clk  in  1  beat clock, asynchronous to clk
next_arrow  in  ARROW_W  code inserted into slot 0 on each shift
hit  in  1  one-cycle pulse: player matched the slot DEPTH-1 arrow
arrows  out  DEPTH*ARROW_W  slot i at bits [i*ARROW_W +: ARROW_W]; slot 0 is newest
step  out  1  one-cycle pulse, registered; asserted on the cycle a shift is applied
miss  out  1  one-cycle pulse; a non-empty, unconsumed arrow left slot DEPTH-1
miss_arrow  out  ARROW_W  code of the missed arrow, valid while miss=1
occupancy  out  $clog2(DEPTH+1)  number of slots not equal to EMPTY_CODE

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - all slots <= EMPTY_CODE; step, miss, occupancy <= 0; miss_arrow <= EMPTY_CODE.
  - Synchroniser and edge-detect flops <= 0.
- Beat detection:
  - metronome_clk passes through two synchroniser flops s1, s2, then a history flop s3.
  - beat = s2 & ~s3.
  - The shift occurs on the clk edge at which beat=1 and state=GAME; step is high for that following cycle.
  - Latency: 3 clk edges from the first edge that samples metronome_clk high to the slot update.
  - One shift per metronome rising edge, regardless of how long metronome_clk stays high.
- GAME with beat:
  - slot0 <= next_arrow; slot[i] <= slot[i-1] for i = 1..DEPTH-1.
  - The outgoing slot[DEPTH-1] sets miss=1 and miss_arrow to its value if it is != EMPTY_CODE and was not hit this cycle.
- GAME with hit and no beat:
  - slot[DEPTH-1] <= EMPTY_CODE; no miss.
  - A hit on an empty slot is a no-op.
- GAME with hit and beat on the same cycle:
  - The hit applies to the outgoing arrow, so no miss.
  - The shift proceeds normally.
- PAUSE (or state=3):
  - Slots frozen; hit ignored; beats discarded.
  - The edge detector keeps running, so there is no stale shift on resume.
  - miss and step stay 0.
- RESET state: same effect as rst_n=0 on slots and outputs; the synchroniser keeps running.
- occupancy:
  - Registered; reflects the post-update slot contents in the same cycle the slots change.
  - Range 0..DEPTH.
- next_arrow == EMPTY_CODE inserts a gap; this is legal and does not count toward occupancy.
- miss and step last exactly one cycle each; miss can only be high on a cycle where step is also high.
- rst_n has priority over state; state RESET has priority over hit and beat.

Decomposition:
- Shared package holds:
  - state codes STATE_GAME/PAUSE/RESET and STATE_BITS;
  - arrow codes ARROW_UP..ARROW_LEFT_RIGHT;
  - ARROW_NONE=20.
- One sub-module, beat_sync:
  - 2-flop synchroniser plus rising-edge pulse generator with synchronous active-low reset.
  - Reusable by the score and display blocks.
- Slot array, hit/miss logic and occupancy stay in arrow_queue.

Test Plan:
1. Reset, GAME, next_arrow=10, one metronome pulse -> step high 3 clks after sampling; slot0=10, others 20; occupancy=1; miss=0.
2. DEPTH=4, GAME, feed 10,11,12,13 on 4 beats, then 14 on a 5th beat with no hit -> slots {14,13,12,11}; miss=1 with miss_arrow=10 for one cycle; occupancy=4.
3. Fill as in scenario 2, pulse hit between beats -> slot3=20 and occupancy=3; next beat gives miss=0.
4. Fill, assert hit on the same cycle beat is internally high -> shift happens and miss=0.
5. GAME, PAUSE, metronome pulse, then back to GAME -> slots unchanged, step never asserted, no shift on resume; hit during PAUSE has no effect.
6. Mid-fill, drive rst_n=0 for one clk (and separately state=RESET) -> all slots 20, occupancy=0, step/miss 0 on the next cycle; held metronome_clk high across reset gives no spurious shift until its next rising edge.
